capture_trigger_buffer: RTL
===========================

// Module: capture_trigger_buffer
// PURPOSE
//  Triggered capture memory directly downstream of the ADC DDR capture stage, in the dclk domain.
//  Accepts 64-bit words carrying four 16-bit lanes, with lane0 = din[15:0] as the newest sample.
//  Stores them in a circular RAM and detects a rising threshold crossing on the lane high byte.
//  Freezes DEPTH words around the trigger (pretrigger history included) and plays them out on a read port.
// PARAMETERS
//  ADDR_W        10    RAM address width; DEPTH = 2**ADDR_W words of 64 bits
//  AUTO_TIMEOUT  4096  valid words spent in ARMED before a self-trigger (AUTO_TRIG_EN builds only)
// PORTS
//  dclk         in   1       single clock; every register in this block is clocked on its rising edge
//  rst          in   1       asynchronous reset, active high
//  din          in   64      four 16-bit lanes from the capture stage; lane k = din[16k+15:16k]
//  din_valid    in   1       din qualifier; when low there is no write, no count and no trigger evaluation
//  arm          in   1       one-cycle pulse that starts a new capture
//  force_trig   in   1       manual trigger; honoured only in ARMED
//  thresh       in   8       unsigned trigger level compared against lane[15:8]
//  pretrig_len  in   ADDR_W  words kept before the trigger word; latched on arm
//  rd_en        in   1       read request; honoured only in DONE
//  rd_data      out  64      read word, valid while rd_valid is high
//  rd_valid     out  1       one-cycle pulse per accepted read
//  busy         out  1       high in PRE, ARMED and POST
//  done         out  1       high in DONE
//  trig_pos     out  ADDR_W  RAM address of the trigger word
//  auto_trig    out  1       high when the last trigger came from the timeout
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; write pointer, read pointer and counters 0; prev_byte=0.
//  States: IDLE, PRE, ARMED, POST, DONE.
//   IDLE/DONE --arm--> PRE
//    - wr_ptr=0, cnt=0.
//    - pre = min(pretrig_len, DEPTH-1).
//   PRE: each valid word is written at wr_ptr; wr_ptr++ wraps mod DEPTH; cnt++.
//    - cnt==pre -> ARMED. With pre=0, ARMED is entered on the cycle after arm.
//   ARMED: writes continue in circular fashion. A valid word with a crossing, or force_trig, fires the trigger:
//    - the trigger word is written;
//    - trig_pos = its address;
//    - post = DEPTH-pre-1;
//    - next state is POST, or DONE directly if post==0.
//   POST: each valid word is written; post--; on reaching 0 -> DONE.
//    - rd_ptr = trig_pos-pre (mod DEPTH), the oldest word kept.
//  Crossing rule: the byte sequence prev_byte, lane3, lane2, lane1, lane0 is scanned oldest to newest.
//   - Any adjacent pair with a<thresh and b>=thresh counts as a crossing.
//   - prev_byte is lane0[15:8] of the last valid word; it is updated on every valid word in every state.
//  Read: each rd_en in DONE reads RAM[rd_ptr]; rd_ptr++ wraps.
//   - rd_data and rd_valid follow 1 cycle later (registered RAM).
//   - After DEPTH reads, rd_en is ignored; done stays high.
//   - rd_data holds its last value when no read is in progress.
//  Simultaneous events:
//   - arm with rd_en in DONE: arm wins and the read is dropped.
//   - arm outside IDLE/DONE: ignored.
//   - force_trig outside ARMED: ignored.
//   - trigger on a word with din_valid low: not possible.
//  Reset during any state returns to IDLE immediately; captured data is discarded.
//  Output timing: busy, done and trig_pos are registered, and change on the clock edge that makes the state transition.
// CONFIGURATION
//  AUTO_TRIG_EN defined:
//   - a timer counts valid words in ARMED and clears on entering ARMED;
//   - reaching AUTO_TIMEOUT fires the trigger as if force_trig were asserted, and sets auto_trig=1;
//   - a real or forced trigger sets auto_trig=0.
//  AUTO_TRIG_EN undefined: there is no timer and auto_trig is tied to 0.
// STRUCTURE
//  Package adc_cap_pkg:
//   - state enum (IDLE, PRE, ARMED, POST, DONE);
//   - LANES=4, LANE_W=16, TRIG_MSB=15, TRIG_LSB=8.
//  One sub-module, cap_sdp_ram: simple dual-port, 64 x DEPTH, registered read, single dclk.
//  Top level holds the FSM, the pointers and counters, and the crossing comparators.
// TESTING
//  T1: reset mid-POST -> all outputs 0 on the next edge; state IDLE; arm restarts a clean capture.
//  T2: ADDR_W=4, pre=4, ramp din with lane high bytes 0x00..0xFF; thresh=0x80.
//   -> trig_pos = address of the word holding the 0x80 byte.
//   -> 16 reads return the 4 words before the trigger word, then the trigger word and 11 after, in order.
//  T3: crossing between the previous word's lane0 (0x7F) and the new word's lane3 (0x80) -> trigger on the new word.
//   Steady 0x90 above thresh -> no trigger.
//  T4: pre=0, force_trig on the first ARMED cycle -> the first read returns the forced word.
//   force_trig in IDLE -> no effect.
//  T5: din_valid toggled 1/0 during PRE/POST -> only valid words are stored; counts are unchanged by invalid cycles.
//   arm+rd_en together in DONE -> restart, no rd_valid.
//  T6 (AUTO_TRIG_EN, AUTO_TIMEOUT=8): no crossing -> trigger on the 8th valid ARMED word; auto_trig=1.
//   Without the macro -> the block stays ARMED and auto_trig=0.

Source files
------------

// File: rtl/adc_cap_pkg.sv
// Shared types and lane geometry for the triggered capture buffer.
package adc_cap_pkg;
    localparam int LANES    = 4;
    localparam int LANE_W   = 16;
    localparam int TRIG_MSB = 15;
    localparam int TRIG_LSB = 8;
    localparam int TRIG_W   = TRIG_MSB - TRIG_LSB + 1;
    localparam int WORD_W   = LANES * LANE_W;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        ARMED,
        POST,
        DONE
    } cap_state_e;
endpackage

// File: rtl/cap_sdp_ram.sv
// Simple dual-port capture RAM: one write port, one registered read port.
module cap_sdp_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64
) (
    input  logic              dclk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge dclk) begin
        if (wr_en) mem_q[wr_addr] <= wr_data;
    end

    // Output register only loads on a read, so the last word is held between reads.
    always_ff @(posedge dclk or posedge rst) begin
        if (rst)        rd_data_q <= '0;
        else if (rd_en) rd_data_q <= mem_q[rd_addr];
    end

    assign rd_data = rd_data_q;
endmodule

// File: rtl/capture_trigger_buffer.sv
// Triggered circular capture of 4-lane ADC words with pretrigger history and read-out port.
// Optional build macro AUTO_TRIG_EN adds a self-trigger after AUTO_TIMEOUT valid words in ARMED.
module capture_trigger_buffer import adc_cap_pkg::*; #(
    parameter int ADDR_W       = 10,
    parameter int AUTO_TIMEOUT = 4096
) (
    input  logic              dclk,
    input  logic              rst,
    input  logic [WORD_W-1:0] din,
    input  logic              din_valid,
    input  logic              arm,
    input  logic              force_trig,
    input  logic [7:0]        thresh,
    input  logic [ADDR_W-1:0] pretrig_len,
    input  logic              rd_en,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] trig_pos,
    output logic              auto_trig
);
    localparam int              DEPTH  = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   RD_ALL = (ADDR_W+1)'(DEPTH);

    cap_state_e        state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] pre_q, pre_d;
    logic [ADDR_W-1:0] trig_pos_q, trig_pos_d;
    logic [ADDR_W:0]   rd_cnt_q, rd_cnt_d;
    logic              auto_q, auto_d;
    logic              busy_q, done_q, rd_valid_q;
    logic [TRIG_W-1:0] prev_q;
    logic              wr_en, rd_fire, fire, crossing, timeout;

    // Byte sequence oldest to newest: previous lane0, then lane3 down to lane0.
    logic [LANES:0][TRIG_W-1:0] seq_bytes;
    logic [LANES-1:0]           cross_pair;

    assign seq_bytes[0] = prev_q;
    for (genvar gi = 0; gi < LANES; gi++) begin : g_bytes
        assign seq_bytes[gi+1] = din[(LANES-1-gi)*LANE_W + TRIG_MSB -: TRIG_W];
    end
    for (genvar gi = 0; gi < LANES; gi++) begin : g_cross
        assign cross_pair[gi] = (seq_bytes[gi] < thresh) && (seq_bytes[gi+1] >= thresh);
    end
    assign crossing = |cross_pair;

`ifdef AUTO_TRIG_EN
    localparam int TMR_W = $clog2(AUTO_TIMEOUT + 1);
    logic [TMR_W-1:0] timer_q, timer_d;

    always_comb begin
        timer_d = '0;
        if (state_q == ARMED) timer_d = din_valid ? timer_q + 1'b1 : timer_q;
    end

    always_ff @(posedge dclk or posedge rst) begin
        if (rst) timer_q <= '0;
        else     timer_q <= timer_d;
    end

    assign timeout = (state_q == ARMED) && din_valid && (timer_q == TMR_W'(AUTO_TIMEOUT - 1));
`else
    // No timer in this build; the parameter stays referenced so both builds share one port list.
    assign timeout = 1'b0 && (AUTO_TIMEOUT > 0);
`endif

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        pre_d      = pre_q;
        trig_pos_d = trig_pos_q;
        rd_cnt_d   = rd_cnt_q;
        auto_d     = auto_q;
        wr_en      = 1'b0;
        rd_fire    = 1'b0;
        fire       = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (arm) begin
                    state_d  = PRE;
                    wr_ptr_d = '0;
                    cnt_d    = '0;
                    rd_cnt_d = '0;
                    pre_d    = (pretrig_len > LAST) ? LAST : pretrig_len;
                end else if (state_q == DONE && rd_en && rd_cnt_q != RD_ALL) begin
                    rd_fire  = 1'b1;
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end
            end
            PRE: begin
                wr_en = din_valid;
                if (din_valid) cnt_d = cnt_q + 1'b1;
                // Leave as soon as pre words are in the RAM; pre=0 leaves on the first PRE cycle.
                if (cnt_q == pre_q || (din_valid && cnt_q + 1'b1 == pre_q)) state_d = ARMED;
            end
            ARMED: begin
                wr_en = din_valid;
                fire  = din_valid && (crossing || force_trig || timeout);
                if (fire) begin
                    trig_pos_d = wr_ptr_q;
                    rd_ptr_d   = wr_ptr_q - pre_q;
                    cnt_d      = LAST - pre_q;
                    auto_d     = !(crossing || force_trig);
                    state_d    = (pre_q == LAST) ? DONE : POST;
                end
            end
            POST: begin
                wr_en = din_valid;
                if (din_valid) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == ADDR_W'(1)) state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    end

    always_ff @(posedge dclk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            pre_q      <= '0;
            trig_pos_q <= '0;
            rd_cnt_q   <= '0;
            auto_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            prev_q     <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            pre_q      <= pre_d;
            trig_pos_q <= trig_pos_d;
            rd_cnt_q   <= rd_cnt_d;
            auto_q     <= auto_d;
            busy_q     <= state_d inside {PRE, ARMED, POST};
            done_q     <= (state_d == DONE);
            rd_valid_q <= rd_fire;
            if (din_valid) prev_q <= din[TRIG_MSB:TRIG_LSB];
        end
    end

    cap_sdp_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (WORD_W)
    ) u_ram (
        .dclk    (dclk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data (din),
        .rd_en   (rd_fire),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_data)
    );

    assign rd_valid  = rd_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign trig_pos  = trig_pos_q;
    assign auto_trig = auto_q;
endmodule
